// File: rtl/branch_target_table.sv
// Runtime-programmable branch target table: indexed lookup with one-cycle
// registered result and a timed bulk-invalidate sweep. Optional macro BTT_WR_BYPASS_EN.
module branch_target_table #(
  parameter int                 IDX_W     = 5,
  parameter int                 DEPTH     = 32,
  parameter int                 ADDR_W    = 16,
  parameter logic [ADDR_W-1:0]  MISS_ADDR = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [IDX_W-1:0]  wr_idx,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic              clr,
  input  logic              rd_en,
  input  logic [IDX_W-1:0]  rd_idx,
  output logic [ADDR_W-1:0] targ_addr,
  output logic              targ_hit,
  output logic              targ_valid,
  output logic              busy,
  output logic [IDX_W:0]    valid_cnt
);

  localparam int             AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [IDX_W:0] DEPTH_W  = (IDX_W+1)'(DEPTH);
  localparam logic [AW-1:0]  LAST_PTR = AW'(DEPTH - 1);

  typedef enum logic {S_IDLE, S_SWEEP} state_t;

  state_t              state_reg, state_next;
  logic [AW-1:0]       ptr_reg, ptr_next;
  logic [DEPTH-1:0]    valid_reg, valid_next;
  logic [IDX_W:0]      cnt_reg, cnt_next;
  logic [ADDR_W-1:0]   mem [DEPTH];

  logic [ADDR_W-1:0]   addr_reg, addr_next;
  logic                hit_reg, hit_next;
  logic                tvalid_reg;

  logic                busy_int;
  logic                sweeping;
  logic                wr_in_range, rd_in_range;
  logic                wr_accept;
  logic                rd_hit_stored;
  logic                rd_bypass;
  logic [AW-1:0]       wr_slot, rd_slot;
  logic                cnt_inc, cnt_dec;

  assign wr_slot     = wr_idx[AW-1:0];
  assign rd_slot     = rd_idx[AW-1:0];
  assign wr_in_range = ({1'b0, wr_idx} < DEPTH_W);
  assign rd_in_range = ({1'b0, rd_idx} < DEPTH_W);

  // A clr pulse in the same cycle takes priority and drops the write.
  assign wr_accept   = wr_en & ~busy_int & ~clr & wr_in_range;
  assign sweeping    = (state_reg == S_SWEEP);

  // ---------------- sweep FSM: state register ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= S_IDLE;
      ptr_reg   <= '0;
    end else begin
      state_reg <= state_next;
      ptr_reg   <= ptr_next;
    end
  end

  // ---------------- sweep FSM: next state ----------------
  always_comb begin
    state_next = state_reg;
    ptr_next   = ptr_reg;
    unique case (state_reg)
      S_IDLE: begin
        if (clr) begin
          state_next = S_SWEEP;
          ptr_next   = '0;
        end
      end
      S_SWEEP: begin
        ptr_next = ptr_reg + AW'(1);
        if (ptr_reg == LAST_PTR) begin
          state_next = S_IDLE;
          ptr_next   = '0;
        end
      end
      default: begin
        state_next = S_IDLE;
        ptr_next   = '0;
      end
    endcase
  end

  // ---------------- sweep FSM: outputs ----------------
  always_comb begin
    busy_int = 1'b0;
    if (state_reg == S_SWEEP) busy_int = 1'b1;
  end

  // ---------------- valid vector, one next-state term per entry ----------------
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_valid
      always_comb begin
        valid_next[gi] = valid_reg[gi];
        if (wr_accept && (wr_slot == AW'(gi)))
          valid_next[gi] = 1'b1;
        else if (sweeping && (ptr_reg == AW'(gi)))
          valid_next[gi] = 1'b0;
      end
    end
  endgenerate

  // Writes and sweep clears never coincide, so at most one of inc/dec is set.
  assign cnt_inc  = wr_accept & ~valid_reg[wr_slot];
  assign cnt_dec  = sweeping & valid_reg[ptr_reg];

  always_comb begin
    cnt_next = cnt_reg;
    if (cnt_inc)
      cnt_next = cnt_reg + (IDX_W+1)'(1);
    else if (cnt_dec)
      cnt_next = cnt_reg - (IDX_W+1)'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_reg <= '0;
      cnt_reg   <= '0;
    end else begin
      valid_reg <= valid_next;
      cnt_reg   <= cnt_next;
    end
  end

  // ---------------- data array (not reset) ----------------
  always_ff @(posedge clk) begin
    if (wr_accept)
      mem[wr_slot] <= wr_addr;
  end

  // ---------------- lookup ----------------
  assign rd_hit_stored = rd_en & rd_in_range & ~busy_int & valid_reg[rd_slot];

`ifdef BTT_WR_BYPASS_EN
  // Forward the in-flight write so the same-cycle lookup sees the new target.
  assign rd_bypass = rd_en & wr_accept & (wr_idx == rd_idx);
`else
  assign rd_bypass = 1'b0;
`endif

  always_comb begin
    addr_next = addr_reg;
    hit_next  = hit_reg;
    if (rd_en) begin
      if (rd_bypass) begin
        addr_next = wr_addr;
        hit_next  = 1'b1;
      end else if (rd_hit_stored) begin
        addr_next = mem[rd_slot];
        hit_next  = 1'b1;
      end else begin
        addr_next = MISS_ADDR;
        hit_next  = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_reg   <= MISS_ADDR;
      hit_reg    <= 1'b0;
      tvalid_reg <= 1'b0;
    end else begin
      addr_reg   <= addr_next;
      hit_reg    <= hit_next;
      tvalid_reg <= rd_en;
    end
  end

  assign targ_addr  = addr_reg;
  assign targ_hit   = hit_reg;
  assign targ_valid = tvalid_reg;
  assign busy       = busy_int;
  assign valid_cnt  = cnt_reg;

endmodule
